// File: rtl/srl_pkg.sv
// rtl/srl_pkg.sv - shared constants and elaboration helpers for addressable shift registers
//
// Purpose : depth constants for the 16- and 32-deep shift-register styles,
//           tap-address width derivation and depth legality check.
// Ports   : none (package)

package srl_pkg;

  localparam int SRL16_DEPTH = 16;
  localparam int SRL32_DEPTH = 32;

  // Only the two depths the vendor primitives provide are legal.
  function automatic bit srl_depth_ok(input int depth);
    return (depth == SRL16_DEPTH) || (depth == SRL32_DEPTH);
  endfunction

  // Tap address width for a legal depth (4 for 16, 5 for 32).
  function automatic int srl_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/srl_addr_shift.sv
// rtl/srl_addr_shift.sv - addressable shift register with dynamic tap and cascade output
//
// Purpose : single-bit delay line of DEPTH stages (16 or 32) with a
//           combinational tap mux and a last-stage cascade output.
//           Asynchronous reset reloads INIT.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset, restores INIT
//           ce     - shift enable
//           d      - serial data in (enters stage 0)
//           a      - tap select, 0 = newest stage
//           q      - sr[a], combinational
//           q_last - sr[DEPTH-1], cascade output

module srl_addr_shift
  import srl_pkg::*;
#(
  parameter int               DEPTH = SRL32_DEPTH,
  parameter logic [DEPTH-1:0] INIT  = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ce,
  input  logic                          d,
  input  logic [srl_addr_w(DEPTH)-1:0]  a,
  output logic                          q,
  output logic                          q_last
);

  localparam int ADDR_W = srl_addr_w(DEPTH);

  generate
    if (!srl_depth_ok(DEPTH)) begin : g_bad_depth
      $error("srl_addr_shift: DEPTH=%0d is illegal, must be 16 or 32", DEPTH);
    end
  endgenerate

  logic [DEPTH-1:0] sr;

  // Reset branch wins over ce, so an unknown ce cannot disturb contents
  // while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= INIT;
    end else if (ce) begin
      sr <= {sr[DEPTH-2:0], d};
    end
  end

  // Address width covers DEPTH exactly, so every a selects a real stage.
  logic [ADDR_W-1:0] tap;
  assign tap    = a;
  assign q      = sr[tap];
  assign q_last = sr[DEPTH-1];

endmodule

// File: tb/tb_srl_addr_shift.sv
// tb/tb_srl_addr_shift.sv - self-checking bench for srl_addr_shift

module tb_srl_addr_shift;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  // Instance A: DEPTH 32, non-zero INIT
  logic       ce_a = 1'b0, d_a = 1'b0;
  logic [4:0] a_a = '0;
  logic       q_a, ql_a;

  // Instance B: DEPTH 16, zero INIT
  logic       ce_b = 1'b0, d_b = 1'b0;
  logic [3:0] a_b = '0;
  logic       q_b, ql_b;

  // Instances C1 -> C2: DEPTH 32 cascade, common ce
  logic       ce_c = 1'b0, d_c = 1'b0;
  logic [4:0] a_c1 = '0, a_c2 = '0;
  logic       q_c1, ql_c1, q_c2, ql_c2;

  srl_addr_shift #(.DEPTH(32), .INIT(32'hA5A5_0F0F)) u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce_a), .d(d_a), .a(a_a), .q(q_a), .q_last(ql_a));

  srl_addr_shift #(.DEPTH(16), .INIT(16'h0000)) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce_b), .d(d_b), .a(a_b), .q(q_b), .q_last(ql_b));

  srl_addr_shift #(.DEPTH(32), .INIT(32'h0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .ce(ce_c), .d(d_c), .a(a_c1), .q(q_c1), .q_last(ql_c1));

  srl_addr_shift #(.DEPTH(32), .INIT(32'h0)) u_c2 (
    .clk(clk), .rst_n(rst_n), .ce(ce_c), .d(ql_c1), .a(a_c2), .q(q_c2), .q_last(ql_c2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] a;
    logic       exp_q;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] init_a;
    logic [31:0] word;
    logic [3:0]  pat;

    // DEADBEEF bit values at selected taps, derived by hand from the hex digits
    vecs[0]  = '{5'd0,  1'b1};
    vecs[1]  = '{5'd4,  1'b0};
    vecs[2]  = '{5'd8,  1'b0};
    vecs[3]  = '{5'd12, 1'b1};
    vecs[4]  = '{5'd14, 1'b0};
    vecs[5]  = '{5'd16, 1'b1};
    vecs[6]  = '{5'd17, 1'b0};
    vecs[7]  = '{5'd20, 1'b0};
    vecs[8]  = '{5'd23, 1'b1};
    vecs[9]  = '{5'd24, 1'b0};
    vecs[10] = '{5'd29, 1'b0};
    vecs[11] = '{5'd31, 1'b1};

    init_a = 32'hA5A5_0F0F;
    word   = 32'hDEAD_BEEF;

    // ---- 1. Reset contents and asynchronous reload ----
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      a_a = i[4:0];
      #1 check($sformatf("rst_q_a%0d", i), q_a, init_a[i]);
    end
    check("rst_q_last", ql_a, 1'b1);

    // Unknown ce while reset is held must not disturb contents
    ce_a = 1'bx;
    d_a  = 1'b0;
    edge_step();
    edge_step();
    a_a = 5'd0;
    #1 check("rst_ce_x_q0", q_a, 1'b1);
    check("rst_ce_x_qlast", ql_a, 1'b1);

    // Release, corrupt with eight zeros
    ce_a = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) edge_step();
    check("corrupt_q0", q_a, 1'b0);
    a_a = 5'd7;
    #1 check("corrupt_q7", q_a, 1'b0);

    // Mid-cycle reset, no clock edge: immediate reload
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      a_a = i[4:0];
      #1 check($sformatf("async_q_a%0d", i), q_a, init_a[i]);
    end
    ce_a = 1'b0;
    edge_step();
    rst_n = 1'b1;

    // ---- 2. Fixed-tap latency on 16-deep ----
    a_b  = 4'd5;
    ce_b = 1'b1;
    d_b  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      edge_step();
      d_b = 1'b0;
      check($sformatf("lat_q_e%0d", k), q_b, (k == 6));
      check($sformatf("lat_qlast_e%0d", k), ql_b, (k == 16));
    end
    ce_b = 1'b0;

    // ---- 3. Enable gating on 32-deep, a=3 ----
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    a_c1 = 5'd3;
    ce_c = 1'b1;
    pat  = 4'b1011;  // shifted in as 1,0,1,1
    for (int k = 3; k >= 0; k--) begin
      d_c = pat[k];
      edge_step();
    end
    check("gate_q_before", q_c1, 1'b1);
    ce_c = 1'b0;
    for (int k = 0; k < 7; k++) begin
      d_c = k[0];
      edge_step();
      check($sformatf("gate_hold_c%0d", k), q_c1, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      a_c1 = k[4:0];
      #1 check($sformatf("gate_tap%0d", k), q_c1, pat[k]);
    end
    a_c1 = 5'd3;
    ce_c = 1'b1;
    d_c  = 1'b0;
    edge_step();
    check("gate_resume1", q_c1, 1'b0);
    edge_step();
    check("gate_resume2", q_c1, 1'b1);
    edge_step();
    check("gate_resume3", q_c1, 1'b1);

    // ---- 4. Dynamic address sweep after shifting DEADBEEF ----
    for (int i = 31; i >= 0; i--) begin
      d_c = word[i];
      edge_step();
    end
    ce_c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a_c1 = vecs[i].a;
      #1 check($sformatf("dyn_tab_a%0d", vecs[i].a), q_c1, vecs[i].exp_q);
    end
    for (int i = 0; i < 32; i++) begin
      a_c1 = i[4:0];
      #1 check($sformatf("dyn_sweep_a%0d", i), q_c1, word[i]);
    end
    check("dyn_qlast", ql_c1, 1'b1);

    // ---- 5. Cascade of two 32-deep instances ----
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    ce_c = 1'b1;
    d_c  = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      edge_step();
      d_c = 1'b0;
      check($sformatf("casc_e%0d", k), ql_c2, (k == 64));
    end
    check("casc_c1_qlast_clear", ql_c1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/srl_addr_shift.md
Name: srl_addr_shift

Overview:
- Behavioural, synthesizable model of the vendor addressable shift-register primitives (16-deep SRL16E style, 32-deep SRLC32E style with cascade output).
- Selected by parameter; single-bit data path.
- Used wherever delay lines need a dynamic tap, and as a portable stand-in for the primitives in simulation.
- Adds an asynchronous active-low reset that restores the INIT contents.

Parameters:
DEPTH, 32, number of storage stages; legal values 16 or 32 only (any other value is an elaboration error)
INIT, all zeros (DEPTH bits), initial/reset contents; bit 0 = stage nearest input
ADDR_W, derived $clog2(DEPTH) (4 or 5), tap address width; not overridable

Ports:
clk     input   1       rising-edge clock
rst_n   input   1       reset, asynchronous, active-low; one clock; reset is asynchronous and active-low
ce      input   1       shift enable, active-high
d       input   1       serial data in
a       input   ADDR_W  dynamic tap select (0 = newest stage)
q       output  1       addressed tap, combinational from storage and a
q_last  output  1       last stage (stage DEPTH-1); cascade output (Q31 equivalent for DEPTH=32, Q15 for DEPTH=16)

Behaviour:
- Storage sr[DEPTH-1:0]. Power-up value equals INIT.
- rst_n low: sr = INIT immediately (asynchronous). While low, shifts are blocked. Release is synchronous to the next rising clk; the first shift happens on the first edge with rst_n high and ce high.
- Rising clk, rst_n high, ce=1: sr <= {sr[DEPTH-2:0], d}.
- Rising clk, rst_n high, ce=0: sr holds.
- q = sr[a], combinational.
  - A change on a alters q in the same cycle, with no clock needed.
  - The value on d appears on q after a+1 enabled edges (latency = a+1 ce-qualified cycles).
- q_last = sr[DEPTH-1], independent of a. d appears there after DEPTH enabled edges.
- Reset outputs: q = INIT[a]; q_last = INIT[DEPTH-1].
- Every a value is a legal address (the address width exactly covers DEPTH), so no out-of-range case exists.
- Cascade: feeding q_last of one instance into d of the next, with a common ce, yields a 2*DEPTH-stage line.
- ce going low mid-stream freezes contents exactly; data resumes from the same position when ce returns high.
- Reset asserted mid-operation discards all shifted data and reloads INIT.
- No X propagation from an unknown ce when rst_n is low.

Decomposition:
- Shared package srl_pkg holds:
  - constants SRL16_DEPTH=16 and SRL32_DEPTH=32;
  - a function returning ADDR_W for a legal depth;
  - a function validating DEPTH, used by an elaboration-time check.
- No sub-module. Storage, shift, and mux are a single block.
- Optional wrapper srl_cascade (not part of this block) chains instances for depths above 32.

Test Plan:
1. Reset: DEPTH=32, INIT=32'hA5A5_0F0F; hold rst_n low, sweep a=0..31 -> q equals INIT[a] and q_last=1. Corrupt contents by shifting, reassert rst_n mid-cycle (no clock) -> q returns to INIT[a] immediately.
2. Fixed-tap latency: DEPTH=16, INIT=0, a=5, ce=1; drive a single-cycle pulse d=1 -> q is 1 exactly on the 6th edge after the pulse and 0 otherwise. q_last pulses on the 16th edge.
3. Enable gating: DEPTH=32, a=3; shift in pattern 1,0,1,1; drop ce for 7 cycles while d toggles -> contents and q unchanged. Restore ce -> pattern continues as if no gap.
4. Dynamic address: DEPTH=32, shift in 32 bits 0xDEADBEEF (MSB first). Sweep a=0..31 without clocking -> q equals the bit shifted in a+1 edges ago (a=0 -> 1, the LSB; a=31 -> 1, the MSB). q_last=1.
5. Cascade: two DEPTH=32 instances chained via q_last->d; pulse d once -> the second instance's q_last pulses after exactly 64 enabled edges.
6. Parameter check: DEPTH=20 -> elaboration fails with an error message; DEPTH=16 and DEPTH=32 both elaborate with ADDR_W of 4 and 5 respectively.
